// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer and register write-port arbiter for the shared multi-cycle FPU.
// Tracks one in-flight op, exports its destination as a scoreboard bit, and arbitrates write-back.
module fpu_issue_ctrl #(
    parameter int unsigned LAT_CVT = 1,
    parameter int unsigned LAT_ADD = 2,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned LAT_INV = 8,
    parameter int unsigned STARVE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [7:0]  issue_op,
    input  logic [3:0]  issue_rd,
    output logic        issue_ready,
    output logic        issue_err,
    input  logic        flush,
    output logic        fpu_start,
    output logic [7:0]  fpu_op,
    input  logic [15:0] fpu_result,
    input  logic        alu_wb_valid,
    output logic        alu_stall,
    output logic        wb_valid,
    output logic [3:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic [15:0] busy_mask
);

    localparam int unsigned SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q;
    logic [SW-1:0]  starve_q;
    logic           is_fpu;
    logic [3:0]     lat;
    logic           accept;
    logic           starved;

    always_comb begin
        is_fpu = 1'b1;
        lat    = 4'd1;
        case (issue_op)
            8'h20, 8'h21, 8'h22, 8'h23,
            8'h26, 8'h27, 8'h28:         lat = 4'(LAT_CVT);
            8'h24, 8'h25:                lat = 4'(LAT_INV);
            8'h60, 8'h61:                lat = 4'(LAT_ADD);
            8'h62, 8'h63:                lat = 4'(LAT_MUL);
            default:                     is_fpu = 1'b0;
        endcase
    end

    assign starved     = starve_q >= SW'(STARVE);
    assign issue_ready = (state_q == StIdle) && !flush && is_fpu;
    assign accept      = issue_valid && issue_ready;
    // A flush on the granting edge suppresses the write, so the grant itself is withheld.
    assign wb_valid    = (state_q == StWb) && !flush && (!alu_wb_valid || starved);
    assign alu_stall   = alu_wb_valid && wb_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec: begin
                if (flush)              state_d = StIdle;
                else if (cnt_q == 4'd0) state_d = StWb;
            end
            StWb:    if (flush || wb_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= 4'd0;
            starve_q  <= '0;
            fpu_start <= 1'b0;
            fpu_op    <= 8'h00;
            wb_reg    <= 4'd0;
            wb_data   <= 16'h0000;
            busy_mask <= 16'h0000;
            issue_err <= 1'b0;
        end else begin
            fpu_start <= accept;
            issue_err <= (state_q == StIdle) && issue_valid && !is_fpu;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        fpu_op    <= issue_op;
                        wb_reg    <= issue_rd;
                        busy_mask <= 16'h0001 << issue_rd;
                        cnt_q     <= lat - 4'd1;
                        starve_q  <= '0;
                    end
                end
                StExec: begin
                    if (flush) begin
                        busy_mask <= 16'h0000;
                    end else if (cnt_q == 4'd0) begin
                        wb_data <= fpu_result;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWb: begin
                    if (flush || wb_valid) begin
                        busy_mask <= 16'h0000;
                        starve_q  <= '0;
                    end else if (!starved) begin
                        starve_q <= starve_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: decode table, directed corner sequences,
// and randomized traffic against a transaction-level model.
module tb_fpu_issue_ctrl;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [7:0]  issue_op = 8'h00;
    logic [3:0]  issue_rd = 4'd0;
    logic        issue_ready, issue_err;
    logic        flush = 1'b0;
    logic        fpu_start;
    logic [7:0]  fpu_op;
    logic [15:0] fpu_result = 16'h0000;
    logic        alu_wb_valid = 1'b0;
    logic        alu_stall, wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data, busy_mask;

    fpu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_err(issue_err), .flush(flush),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_result(fpu_result),
        .alu_wb_valid(alu_wb_valid), .alu_stall(alu_stall), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_data(wb_data), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endfunction

    // Latency by opcode class; 0 means not an FPU opcode.
    function automatic int lat_of(logic [7:0] op);
        if (op == 8'h24 || op == 8'h25) return 8;
        if (op >= 8'h20 && op <= 8'h28) return 1;
        if (op == 8'h60 || op == 8'h61) return 2;
        if (op == 8'h62 || op == 8'h63) return 3;
        return 0;
    endfunction

    // Transaction model: one pending op, aged in edges since its accept edge.
    bit          m_pend, m_start, m_err;
    int          m_age, m_lat, m_lost;
    logic [3:0]  m_rd, m_wbreg;
    logic [7:0]  m_fop;
    logic [15:0] m_data;
    bit          s_ready, s_wb, s_stall, s_start;

    function automatic void model_reset();
        m_pend = 0; m_start = 0; m_err = 0; m_age = 0; m_lat = 0; m_lost = 0;
        m_rd = 0; m_wbreg = 0; m_fop = 0; m_data = 0;
    endfunction

    // Called at posedge+1; drives one cycle, checks at negedge, advances the model at the edge.
    task automatic cycle(input bit v, input logic [7:0] op, input logic [3:0] rd,
                         input bit fl, input bit alu, input logic [15:0] res);
        bit e_ready, e_wb, acc, fpu;
        issue_valid = v; issue_op = op; issue_rd = rd; flush = fl;
        alu_wb_valid = alu; fpu_result = res;
        @(negedge clk);
        fpu     = lat_of(op) != 0;
        e_ready = !m_pend && !fl && fpu;
        e_wb    = m_pend && m_age >= m_lat && !fl && (!alu || m_lost >= STARVE);
        s_ready = issue_ready; s_wb = wb_valid; s_stall = alu_stall; s_start = fpu_start;
        chk("issue_ready", issue_ready, e_ready);
        chk("wb_valid", wb_valid, e_wb);
        chk("alu_stall", alu_stall, alu && e_wb);
        chk("busy_mask", busy_mask, m_pend ? (16'h1 << m_rd) : 16'h0);
        chk("fpu_start", fpu_start, m_start);
        chk("issue_err", issue_err, m_err);
        chk("fpu_op", fpu_op, m_fop);
        chk("wb_reg", wb_reg, m_wbreg);
        chk("wb_data", wb_data, m_data);
        acc = v && e_ready;
        @(posedge clk);
        m_start = acc;
        m_err   = !m_pend && v && !fpu;
        if (m_pend) begin
            if (fl || e_wb) begin
                m_pend = 0; m_lost = 0;
            end else begin
                if (m_age == m_lat - 1) m_data = res;
                if (m_age >= m_lat && m_lost < STARVE) m_lost++;
                m_age++;
            end
        end else if (acc) begin
            m_pend = 1; m_age = 0; m_lat = lat_of(op); m_rd = rd;
            m_fop = op; m_wbreg = rd; m_lost = 0;
        end
        #1;
    endtask

    task automatic idle_cycle();
        cycle(0, 8'h00, 4'd0, 0, 0, 16'h0000);
    endtask

    typedef struct {
        logic [7:0] op;
        logic [3:0] rd;
        bit         ready;
        int         lat;
    } vec_t;

    vec_t vecs[14];
    logic [7:0] rand_ops[18];

    initial begin
        int n;
        bit done;
        vecs[0]  = '{8'h20, 4'd1, 1, 1};  vecs[1]  = '{8'h23, 4'd2, 1, 1};
        vecs[2]  = '{8'h24, 4'd3, 1, 8};  vecs[3]  = '{8'h26, 4'd4, 1, 1};
        vecs[4]  = '{8'h28, 4'd5, 1, 1};  vecs[5]  = '{8'h29, 4'd6, 0, 0};
        vecs[6]  = '{8'h1f, 4'd7, 0, 0};  vecs[7]  = '{8'h60, 4'd8, 1, 2};
        vecs[8]  = '{8'h61, 4'd9, 1, 2};  vecs[9]  = '{8'h62, 4'd10, 1, 3};
        vecs[10] = '{8'h63, 4'd11, 1, 3}; vecs[11] = '{8'h64, 4'd12, 0, 0};
        vecs[12] = '{8'h25, 4'd0, 1, 8};  vecs[13] = '{8'h00, 4'd13, 0, 0};
        rand_ops = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
                     8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h00, 8'h29, 8'h64, 8'h1f};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_mask, 16'h0);
        chk("rst_start", fpu_start, 1'b0);
        chk("rst_fpu_op", fpu_op, 8'h00);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_reg", wb_reg, 4'd0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_err", issue_err, 1'b0);
        chk("rst_stall", alu_stall, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // addf rd=3, ALU idle
        cycle(1, 8'h60, 4'd3, 0, 0, 16'h0000);
        chk("addf_accept", s_ready, 1'b1);
        chk("addf_busy", busy_mask, 16'h0008);
        chk("addf_start_hi", fpu_start, 1'b1);
        cycle(0, 8'h00, 4'd0, 0, 0, 16'h1111);
        chk("addf_no_wb1", s_wb, 1'b0);
        chk("addf_start_lo", fpu_start, 1'b0);
        cycle(0, 8'h00, 4'd0, 0, 0, 16'ha5a5);
        chk("addf_no_wb2", s_wb, 1'b0);
        cycle(0, 8'h00, 4'd0, 0, 0, 16'h2222);
        chk("addf_wb", s_wb, 1'b1);
        chk("addf_wb_reg", wb_reg, 4'd3);
        chk("addf_wb_data", wb_data, 16'ha5a5);
        chk("addf_busy_clr", busy_mask, 16'h0);

        // invf rd=15, next op held valid: accepted on edge T+10
        cycle(1, 8'h24, 4'd15, 0, 0, 16'h0);
        done = 0;
        for (int i = 1; i <= 20 && !done; i++) begin
            cycle(1, 8'h60, 4'd2, 0, 0, 16'h3c3c);
            if (s_ready) begin
                chk("invf_next_edge", i, 10);
                done = 1;
            end
        end
        if (!done) chk("invf_timeout", 0, 1);
        repeat (4) idle_cycle();

        // mulf rd=1 with ALU contending; repeated to show the starve counter cleared
        for (int k = 0; k < 2; k++) begin
            cycle(1, 8'h62, 4'd1, 0, 1, 16'h0);
            for (int i = 1; i <= 8; i++) begin
                cycle(0, 8'h00, 4'd0, 0, 1, 16'h4d00 + 16'(i));
                chk("mulf_wb", s_wb, i == 8);
                chk("mulf_stall", s_stall, i == 8);
            end
            chk("mulf_busy_clr", busy_mask, 16'h0);
        end

        // flush in the 2nd EXEC cycle of mulf rd=7
        cycle(1, 8'h62, 4'd7, 0, 0, 16'h0);
        cycle(0, 8'h00, 4'd0, 0, 0, 16'h0);
        cycle(0, 8'h00, 4'd0, 1, 0, 16'h0);
        chk("flush_no_wb", s_wb, 1'b0);
        chk("flush_busy", busy_mask, 16'h0);
        cycle(1, 8'h61, 4'd5, 0, 0, 16'h0);
        chk("flush_reissue", s_ready, 1'b1);
        chk("flush_reissue_busy", busy_mask, 16'h0020);
        repeat (4) idle_cycle();

        // non-FPU opcode
        cycle(1, 8'h70, 4'd4, 0, 0, 16'h0);
        chk("addi_ready", s_ready, 1'b0);
        chk("addi_err_hi", issue_err, 1'b1);
        idle_cycle();
        chk("addi_err_lo", issue_err, 1'b0);
        chk("addi_busy", busy_mask, 16'h0);

        // decode table: acceptance and write-back edge per opcode
        foreach (vecs[j]) begin
            cycle(1, vecs[j].op, vecs[j].rd, 0, 0, 16'h0);
            chk("tbl_ready", s_ready, vecs[j].ready);
            if (vecs[j].ready) begin
                n = 0;
                for (int i = 1; i <= 20 && n == 0; i++) begin
                    cycle(0, 8'h00, 4'd0, 0, 0, 16'(j * 16'h0101));
                    if (s_wb) n = i;
                end
                chk("tbl_wb_edge", n, vecs[j].lat + 1);
            end
            idle_cycle();
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 1), rand_ops[$urandom_range(0, 17)], 4'($urandom),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6, 16'($urandom));
        end
        repeat (12) idle_cycle();

        // async reset mid-EXEC of invf
        cycle(1, 8'h25, 4'd9, 0, 0, 16'h0);
        cycle(0, 8'h00, 4'd0, 0, 0, 16'h0);
        cycle(0, 8'h00, 4'd0, 0, 0, 16'h0);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy_mask, 16'h0);
        chk("arst_start", fpu_start, 1'b0);
        chk("arst_fpu_op", fpu_op, 8'h00);
        chk("arst_wb_valid", wb_valid, 1'b0);
        chk("arst_wb_reg", wb_reg, 4'd0);
        chk("arst_wb_data", wb_data, 16'h0);
        chk("arst_err", issue_err, 1'b0);
        chk("arst_stall", alu_stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            idle_cycle();
            chk("arst_no_wb", s_wb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
